// File: rtl/frq_code_pkg.sv
// Shared types and constants for the frequency-code receiver.
// Each code k is a square wave with period base_period*(k+1) clk cycles.
package frq_code_pkg;

    localparam int CODE_W    = 3;
    localparam int NUM_CODES = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic int nominal_period(input int k, input int base_period);
        return base_period * (k + 1);
    endfunction

    // One past the longest accepted period, so a silent line is never mistaken for code 7.
    function automatic int timeout_cycles(input int base_period, input int tol);
        return NUM_CODES * base_period + tol + 1;
    endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Two-flop synchroniser for an asynchronous input plus a one-cycle rising-edge pulse.
module sig_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q_sync,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign q_sync = sync2;
    assign rise   = sync2 & ~prev;

endmodule

// File: rtl/frq_code_decoder.sv
// Measures the period of an incoming square wave, classifies it into a 3-bit code and
// publishes the code once it has been seen STABLE_CNT times in a row.
module frq_code_decoder
    import frq_code_pkg::*;
#(
    parameter int BASE_PERIOD = 16,
    parameter int TOL         = 2,
    parameter int STABLE_CNT  = 3,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    output logic [2:0] code,
    output logic       code_valid,
    output logic       code_stb,
    output logic       period_err,
    output logic       sig_lost
);

    localparam int                 TIMEOUT     = timeout_cycles(BASE_PERIOD, TOL);
    localparam int                 MATCH_W     = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [MATCH_W-1:0] MATCH_FULL  = MATCH_W'(STABLE_CNT);

    state_t             state;
    state_t             state_next;
    logic               sig_sync;
    logic               rise;
    logic               edge_seen;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   meas;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_inc;
    logic [CODE_W-1:0]  cand;
    logic [CODE_W-1:0]  cand_prev;
    logic               hit;
    logic               timeout;
    logic               promote;
    logic               code_valid_next;
    logic               code_stb_next;
    logic               period_err_next;
    logic               sig_lost_next;

    sig_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (sig_in),
        .q_sync (sig_sync),
        .rise   (rise)
    );

    assign edge_seen = rise & sig_sync;

    // cnt is the number of cycles since the previous edge pulse, so on an edge it is the period.
    assign meas = cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (edge_seen) begin
            cnt <= CNT_W'(1);
        end else if (cnt != TIMEOUT_CNT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // One extra bit keeps the window bounds and the comparison free of wrap-around.
    always_comb begin
        hit  = 1'b0;
        cand = '0;
        for (int k = 0; k < NUM_CODES; k++) begin
            if ({1'b0, meas} >= (CNT_W+1)'(nominal_period(k, BASE_PERIOD) - TOL) &&
                {1'b0, meas} <= (CNT_W+1)'(nominal_period(k, BASE_PERIOD) + TOL)) begin
                hit  = 1'b1;
                cand = CODE_W'(k);
            end
        end
    end

    assign timeout   = (state != IDLE) && !edge_seen && (cnt == TIMEOUT_CNT);
    assign match_inc = (match_cnt != '0 && cand == cand_prev) ? match_cnt + 1'b1 : MATCH_W'(1);
    assign promote   = edge_seen && hit && match_inc == MATCH_FULL &&
                       (state == MEASURE || (state == LOCKED && cand != code));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (edge_seen) state_next = MEASURE;
            MEASURE: begin
                if (promote)      state_next = LOCKED;
                else if (timeout) state_next = IDLE;
            end
            LOCKED:  if (timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        code_valid_next = (state_next == LOCKED);
        code_stb_next   = promote;
        period_err_next = edge_seen && !hit && (state != IDLE);
        sig_lost_next   = timeout && (state == LOCKED);
    end

    // A period matching the locked code also discards any half-built rival candidate.
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_cnt  <= '0;
            cand_prev  <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            code_stb   <= 1'b0;
            period_err <= 1'b0;
            sig_lost   <= 1'b0;
        end else begin
            code_valid <= code_valid_next;
            code_stb   <= code_stb_next;
            period_err <= period_err_next;
            sig_lost   <= sig_lost_next;
            if (edge_seen && state != IDLE) begin
                if (!hit) begin
                    match_cnt <= '0;
                end else if (state == LOCKED && cand == code) begin
                    match_cnt <= MATCH_FULL;
                    cand_prev <= cand;
                end else begin
                    match_cnt <= match_inc;
                    cand_prev <= cand;
                end
                if (promote) code <= cand;
            end else if (timeout) begin
                match_cnt <= '0;
            end
        end
    end

endmodule
